// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
//
// Sequences a two-approach intersection: main street (NS) and side street (EW).
// NS green is the rest state. EW green is requested by the EW vehicle sensor or
// by a latched pedestrian call. An emergency preemption can shorten NS green,
// hold either green, and pick the green that follows an all-red clearance.
// Every direction change goes through yellow and then all-red. All timing is
// counted in clock cycles.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous reset, active-low (0 = reset)
//   i_ew_req     EW vehicle sensor, level
//   i_ped_req    pedestrian button, a single-cycle pulse is enough (latched)
//   i_emg_req    emergency preemption, level
//   i_emg_dir    preempt direction: 0 = NS, 1 = EW
//   o_ns_r/y/g   NS lamps, one-hot
//   o_ew_r/y/g   EW lamps, one-hot
//   o_walk       pedestrian walk, runs at the start of EW green
//   o_ped_ack    single-cycle pulse on the first cycle of walk
//   o_phase      current state code (NS_G=0 .. AR_TO_NS=5)
// -----------------------------------------------------------------------------
module intersection_phase_scheduler #(
    parameter int CNT_W    = 8,
    parameter int T_GMIN   = 10,
    parameter int T_GMAX   = 30,
    parameter int T_YEL    = 4,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ew_req,
    input  logic       i_ped_req,
    input  logic       i_emg_req,
    input  logic       i_emg_dir,
    output logic       o_ns_r,
    output logic       o_ns_y,
    output logic       o_ns_g,
    output logic       o_ew_r,
    output logic       o_ew_y,
    output logic       o_ew_g,
    output logic       o_walk,
    output logic       o_ped_ack,
    output logic [2:0] o_phase
);

    typedef enum logic [2:0] {
        NS_G     = 3'd0,
        NS_Y     = 3'd1,
        AR_TO_EW = 3'd2,
        EW_G     = 3'd3,
        EW_Y     = 3'd4,
        AR_TO_NS = 3'd5
    } state_t;

    // Exit thresholds are "last cycle" values because the timer reads 0 on entry.
    localparam logic [CNT_W-1:0] C_GMIN_LAST = CNT_W'(T_GMIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX_LAST = CNT_W'(T_GMAX - 1);
    localparam logic [CNT_W-1:0] C_YEL_LAST  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] C_AR_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] C_WALK      = CNT_W'(T_WALK);

    state_t           r_state;
    logic [CNT_W-1:0] r_tmr;
    logic             r_ped_pend;
    logic             r_ns_r, r_ns_y, r_ns_g;
    logic             r_ew_r, r_ew_y, r_ew_g;
    logic             r_walk;
    logic             r_ped_ack;

    state_t           w_next;
    logic [CNT_W-1:0] w_tmr_next;
    logic             w_enter_ewg;
    logic             w_walk_next;
    logic             w_ack_next;

    // Next-state selection. Emergency is examined first in every state that can
    // react to it, so it always beats vehicle and pedestrian requests. Yellow
    // phases ignore everything and simply time out.
    always_comb begin
        w_next = r_state;
        case (r_state)
            NS_G: begin
                if (i_emg_req) begin
                    if (i_emg_dir) w_next = NS_Y;
                end else if ((r_tmr >= C_GMIN_LAST) && (i_ew_req || r_ped_pend)) begin
                    w_next = NS_Y;
                end
            end
            NS_Y: begin
                if (r_tmr >= C_YEL_LAST) w_next = AR_TO_EW;
            end
            AR_TO_EW: begin
                if (r_tmr >= C_AR_LAST) begin
                    if (i_emg_req) w_next = i_emg_dir ? EW_G : NS_G;
                    else           w_next = EW_G;
                end
            end
            EW_G: begin
                if (i_emg_req) begin
                    if (!i_emg_dir) w_next = EW_Y;
                end else if ((r_tmr >= C_GMAX_LAST) ||
                             ((r_tmr >= C_GMIN_LAST) && !i_ew_req)) begin
                    w_next = EW_Y;
                end
            end
            EW_Y: begin
                if (r_tmr >= C_YEL_LAST) w_next = AR_TO_NS;
            end
            AR_TO_NS: begin
                if (r_tmr >= C_AR_LAST) begin
                    if (i_emg_req) w_next = i_emg_dir ? EW_G : NS_G;
                    else           w_next = NS_G;
                end
            end
            default: w_next = AR_TO_NS;
        endcase
    end

    // Timer and walk bookkeeping. Walk is granted only at EW green entry and
    // then runs while the timer stays below the walk length; leaving EW green
    // (e.g. an NS preemption) drops it in the same cycle as ew_g.
    always_comb begin
        w_tmr_next = '0;
        if (w_next == r_state) begin
            w_tmr_next = (r_tmr == '1) ? r_tmr : r_tmr + 1'b1;
        end
        w_enter_ewg = (w_next == EW_G) && (r_state != EW_G);
        w_walk_next = 1'b0;
        if (w_next == EW_G) begin
            w_walk_next = w_enter_ewg ? r_ped_pend : (r_walk && (w_tmr_next < C_WALK));
        end
        w_ack_next = w_enter_ewg && r_ped_pend;
    end

    // State, timer, pedestrian latch and registered outputs. Lamps are decoded
    // from the next state so they change on the same edge as the state register.
    // The pending call is cleared on EW green entry; a press on that very edge
    // is deliberately dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= AR_TO_NS;
            r_tmr      <= '0;
            r_ped_pend <= 1'b0;
            r_ns_r     <= 1'b1;
            r_ns_y     <= 1'b0;
            r_ns_g     <= 1'b0;
            r_ew_r     <= 1'b1;
            r_ew_y     <= 1'b0;
            r_ew_g     <= 1'b0;
            r_walk     <= 1'b0;
            r_ped_ack  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_tmr     <= w_tmr_next;
            r_walk    <= w_walk_next;
            r_ped_ack <= w_ack_next;
            if (w_enter_ewg)    r_ped_pend <= 1'b0;
            else if (i_ped_req) r_ped_pend <= 1'b1;
            r_ns_g <= (w_next == NS_G);
            r_ns_y <= (w_next == NS_Y);
            r_ns_r <= (w_next != NS_G) && (w_next != NS_Y);
            r_ew_g <= (w_next == EW_G);
            r_ew_y <= (w_next == EW_Y);
            r_ew_r <= (w_next != EW_G) && (w_next != EW_Y);
        end
    end

    assign o_ns_r    = r_ns_r;
    assign o_ns_y    = r_ns_y;
    assign o_ns_g    = r_ns_g;
    assign o_ew_r    = r_ew_r;
    assign o_ew_y    = r_ew_y;
    assign o_ew_g    = r_ew_g;
    assign o_walk    = r_walk;
    assign o_ped_ack = r_ped_ack;
    assign o_phase   = r_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_scheduler
//
// Self-checking bench for intersection_phase_scheduler. A short vector table
// covers reset and the first NS green; hand-written sequences then walk
// through vehicle calls, pedestrian calls, both emergency directions, reset in
// the middle of a yellow, and an emergency redirect at the end of all-red.
// Lamp expectations are derived from the expected phase code.
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

    localparam logic [2:0] P_NS_G = 3'd0;
    localparam logic [2:0] P_NS_Y = 3'd1;
    localparam logic [2:0] P_AR_E = 3'd2;
    localparam logic [2:0] P_EW_G = 3'd3;
    localparam logic [2:0] P_EW_Y = 3'd4;
    localparam logic [2:0] P_AR_N = 3'd5;

    logic       clk;
    logic       rst;
    logic       ewReq;
    logic       pedReq;
    logic       emgReq;
    logic       emgDir;
    logic       nsR, nsY, nsG, ewR, ewY, ewG;
    logic       walk;
    logic       pedAck;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       ew;
        logic       ped;
        logic       emg;
        logic       dir;
        logic [2:0] expPhase;
        logic       expWalk;
        logic       expAck;
    } vec_t;

    vec_t vecs[6];

    intersection_phase_scheduler dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ew_req  (ewReq),
        .i_ped_req (pedReq),
        .i_emg_req (emgReq),
        .i_emg_dir (emgDir),
        .o_ns_r    (nsR),
        .o_ns_y    (nsY),
        .o_ns_g    (nsG),
        .o_ew_r    (ewR),
        .o_ew_y    (ewY),
        .o_ew_g    (ewG),
        .o_walk    (walk),
        .o_ped_ack (pedAck),
        .o_phase   (phase)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the stimulus gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected lamp pattern {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g} for a phase code.
    function automatic logic [5:0] lampsFor(input logic [2:0] p);
        case (p)
            P_NS_G:  return 6'b001_100;
            P_NS_Y:  return 6'b010_100;
            P_EW_G:  return 6'b100_001;
            P_EW_Y:  return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    // Advance one clock edge and sample 1 time unit later, checking the
    // lamp-exclusion invariant on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ((nsG | nsY) & (ewG | ewY)) begin
            errors++;
            $display("[TB] FAIL invariant: ns_g/y=%b%b ew_g/y=%b%b required no overlap",
                     nsG, nsY, ewG, ewY);
        end
    endtask

    // Compare all outputs against expectations for the current cycle.
    task automatic checkOutput(input string name, input logic [2:0] expPhase,
                               input logic expWalk, input logic expAck);
        logic [5:0] lamps;
        lamps = {nsR, nsY, nsG, ewR, ewY, ewG};
        checks++;
        if (phase !== expPhase) begin
            errors++;
            $display("[TB] FAIL %s phase: got %0d required %0d", name, phase, expPhase);
        end
        checks++;
        if (lamps !== lampsFor(expPhase)) begin
            errors++;
            $display("[TB] FAIL %s lamps: got %b required %b", name, lamps, lampsFor(expPhase));
        end
        checks++;
        if (walk !== expWalk) begin
            errors++;
            $display("[TB] FAIL %s walk: got %b required %b", name, walk, expWalk);
        end
        checks++;
        if (pedAck !== expAck) begin
            errors++;
            $display("[TB] FAIL %s ped_ack: got %b required %b", name, pedAck, expAck);
        end
    endtask

    // Drive one table vector, clock it, and compare.
    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        ewReq  = v.ew;
        pedReq = v.ped;
        emgReq = v.emg;
        emgDir = v.dir;
        tick();
        checkOutput(v.name, v.expPhase, v.expWalk, v.expAck);
    endtask

    // Run n cycles with inputs held, expecting a fixed phase and walk level;
    // ped_ack is expected only on the first cycle when ackFirst is set.
    task automatic expectRun(input string name, input logic [2:0] p, input logic w,
                             input logic ackFirst, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput(name, p, w, (i == 0) ? ackFirst : 1'b0);
        end
    endtask

    // Main stimulus: table first, then the multi-cycle scenarios in sequence.
    initial begin
        rst = 1'b0; ewReq = 1'b0; pedReq = 1'b0; emgReq = 1'b0; emgDir = 1'b0;

        // Reset held for three edges with conflicting requests active, then
        // released; NS green appears on the second edge after release.
        vecs[0] = '{"reset0",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, P_AR_N, 1'b0, 1'b0};
        vecs[1] = '{"reset1",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, P_AR_N, 1'b0, 1'b0};
        vecs[2] = '{"reset2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_AR_N, 1'b0, 1'b0};
        vecs[3] = '{"rel_ar",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_AR_N, 1'b0, 1'b0};
        vecs[4] = '{"rel_nsg", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_NS_G, 1'b0, 1'b0};
        vecs[5] = '{"ns_rest", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_NS_G, 1'b0, 1'b0};

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Vehicle call from NS green start (cycle 1 of NS green here): EW green
        // extended to the maximum, then back to NS.
        $display("[TB] vehicle call");
        ewReq = 1'b1;
        expectRun("veh_nsg",  P_NS_G, 1'b0, 1'b0, 8);
        expectRun("veh_nsy",  P_NS_Y, 1'b0, 1'b0, 4);
        expectRun("veh_are",  P_AR_E, 1'b0, 1'b0, 2);
        expectRun("veh_ewg",  P_EW_G, 1'b0, 1'b0, 30);
        expectRun("veh_ewy",  P_EW_Y, 1'b0, 1'b0, 4);
        expectRun("veh_arn",  P_AR_N, 1'b0, 1'b0, 2);
        expectRun("veh_back", P_NS_G, 1'b0, 1'b0, 1);
        ewReq = 1'b0;

        // Pedestrian-only call pressed at NS green cycle 3; walk for six cycles,
        // EW green at its minimum. A second press after walk ends is served on
        // the following EW green.
        $display("[TB] pedestrian call");
        expectRun("ped_pre",  P_NS_G, 1'b0, 1'b0, 3);
        pedReq = 1'b1;
        expectRun("ped_prs",  P_NS_G, 1'b0, 1'b0, 1);
        pedReq = 1'b0;
        expectRun("ped_nsg",  P_NS_G, 1'b0, 1'b0, 5);
        expectRun("ped_nsy",  P_NS_Y, 1'b0, 1'b0, 4);
        expectRun("ped_are",  P_AR_E, 1'b0, 1'b0, 2);
        expectRun("ped_walk", P_EW_G, 1'b1, 1'b1, 6);
        expectRun("ped_ewg",  P_EW_G, 1'b0, 1'b0, 2);
        pedReq = 1'b1;
        expectRun("ped_prs2", P_EW_G, 1'b0, 1'b0, 1);
        pedReq = 1'b0;
        expectRun("ped_ewg2", P_EW_G, 1'b0, 1'b0, 1);
        expectRun("ped_ewy",  P_EW_Y, 1'b0, 1'b0, 4);
        expectRun("ped_arn",  P_AR_N, 1'b0, 1'b0, 2);
        expectRun("ped2_nsg", P_NS_G, 1'b0, 1'b0, 10);
        expectRun("ped2_nsy", P_NS_Y, 1'b0, 1'b0, 4);
        expectRun("ped2_are", P_AR_E, 1'b0, 1'b0, 2);
        expectRun("ped2_wlk", P_EW_G, 1'b1, 1'b1, 6);
        expectRun("ped2_ewg", P_EW_G, 1'b0, 1'b0, 4);
        expectRun("ped2_ewy", P_EW_Y, 1'b0, 1'b0, 4);
        expectRun("ped2_arn", P_AR_N, 1'b0, 1'b0, 2);
        expectRun("ped2_bck", P_NS_G, 1'b0, 1'b0, 1);

        // Emergency EW at NS green cycle 2: NS green cut short, EW green held
        // well past the maximum while the preemption stays on.
        $display("[TB] emergency EW");
        expectRun("emg_pre",  P_NS_G, 1'b0, 1'b0, 2);
        emgReq = 1'b1; emgDir = 1'b1;
        expectRun("emg_nsy",  P_NS_Y, 1'b0, 1'b0, 4);
        expectRun("emg_are",  P_AR_E, 1'b0, 1'b0, 2);
        expectRun("emg_hold", P_EW_G, 1'b0, 1'b0, 35);
        emgReq = 1'b0; emgDir = 1'b0;
        expectRun("emg_ewy",  P_EW_Y, 1'b0, 1'b0, 4);
        expectRun("emg_arn",  P_AR_N, 1'b0, 1'b0, 2);
        expectRun("emg_back", P_NS_G, 1'b0, 1'b0, 1);

        // Emergency NS during walk: walk and EW green drop together, the
        // clearance completes, NS green is held under preemption even with a
        // vehicle call, and no pedestrian call is left pending afterwards.
        $display("[TB] emergency NS during walk");
        pedReq = 1'b1;
        expectRun("ew5_prs",  P_NS_G, 1'b0, 1'b0, 1);
        pedReq = 1'b0;
        expectRun("ew5_nsg",  P_NS_G, 1'b0, 1'b0, 8);
        expectRun("ew5_nsy",  P_NS_Y, 1'b0, 1'b0, 4);
        expectRun("ew5_are",  P_AR_E, 1'b0, 1'b0, 2);
        expectRun("ew5_walk", P_EW_G, 1'b1, 1'b1, 3);
        emgReq = 1'b1; emgDir = 1'b0;
        expectRun("ew5_ewy",  P_EW_Y, 1'b0, 1'b0, 4);
        expectRun("ew5_arn",  P_AR_N, 1'b0, 1'b0, 2);
        ewReq = 1'b1;
        expectRun("ew5_hold", P_NS_G, 1'b0, 1'b0, 15);
        emgReq = 1'b0; ewReq = 1'b0;
        expectRun("ew5_idle", P_NS_G, 1'b0, 1'b0, 15);

        // Reset asserted for one cycle in the middle of NS yellow.
        $display("[TB] reset mid-yellow");
        ewReq = 1'b1;
        expectRun("ry_nsy",   P_NS_Y, 1'b0, 1'b0, 2);
        rst = 1'b0;
        expectRun("ry_rst",   P_AR_N, 1'b0, 1'b0, 1);
        rst = 1'b1; ewReq = 1'b0;
        expectRun("ry_ar",    P_AR_N, 1'b0, 1'b0, 1);
        expectRun("ry_nsg",   P_NS_G, 1'b0, 1'b0, 1);

        // Emergency NS present on the last all-red cycle toward EW: the
        // intersection returns to NS green instead of giving EW green.
        $display("[TB] emergency redirect at all-red exit");
        ewReq = 1'b1;
        expectRun("rd_nsg",   P_NS_G, 1'b0, 1'b0, 9);
        expectRun("rd_nsy",   P_NS_Y, 1'b0, 1'b0, 4);
        expectRun("rd_are",   P_AR_E, 1'b0, 1'b0, 1);
        emgReq = 1'b1; emgDir = 1'b0;
        expectRun("rd_are2",  P_AR_E, 1'b0, 1'b0, 1);
        expectRun("rd_nsg2",  P_NS_G, 1'b0, 1'b0, 1);
        emgReq = 1'b0; ewReq = 1'b0;
        expectRun("rd_idle",  P_NS_G, 1'b0, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
